// File: rtl/axis_unpack_pkg.sv
// axis_unpack_pkg: shared defaults, load-source type and helpers
// for the wide-to-narrow AXI-stream unpacker.
package axis_unpack_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_RATIO      = 4;

   // where the shift register takes its next word from
   typedef enum logic [1:0] {
      LD_NONE   = 2'd0,
      LD_BUF    = 2'd1,
      LD_BYPASS = 2'd2
   } load_src_e;

   function automatic int cnt_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/axis_unpack_if.sv
// axis_unpack_if: one AXI-stream channel, width W,
// with master (driver) and slave (receiver) views.
interface axis_unpack_if #(
   parameter int W = 8
) ();

   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (
      output tdata, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tlast,
      output tready
   );

endinterface

// File: rtl/axis_unpack_shift.sv
// axis_unpack_shift: wide shift register, beat counter,
// output slice and registered last-beat flag.
module axis_unpack_shift
   import axis_unpack_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RATIO      = DEF_RATIO,
   parameter int LSB_FIRST  = 1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        load,
   input  logic                        advance,
   input  logic [RATIO*DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0]       beat,
   output logic                        last
);

   localparam int WW = RATIO * DATA_WIDTH;
   localparam int CW = cnt_width(RATIO);
   localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

   logic [WW-1:0] shreg;
   logic [CW-1:0] count;

   // load a fresh word or shift the next slice into the output slot
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg <= '0;
         count <= '0;
         last  <= 1'b0;
      end else if (load) begin
         shreg <= load_data;
         count <= '0;
         last  <= 1'b0;
      end else if (advance) begin
         if (LSB_FIRST != 0)
            shreg <= shreg >> DATA_WIDTH;
         else
            shreg <= shreg << DATA_WIDTH;
         count <= count + 1'b1;
         last  <= (count + 1'b1) == LAST_CNT;
      end
   end

   if (LSB_FIRST != 0) begin : g_lsb
      assign beat = shreg[DATA_WIDTH-1:0];
   end else begin : g_msb
      assign beat = shreg[WW-1 -: DATA_WIDTH];
   end

endmodule

// File: rtl/axis_unpack.sv
// axis_unpack: serializes RATIO*DATA_WIDTH words into RATIO
// narrow beats, one-word skid buffer keeps full throughput.
module axis_unpack
   import axis_unpack_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RATIO      = DEF_RATIO,
   parameter int LSB_FIRST  = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   axis_unpack_if.slave  s_axis,
   axis_unpack_if.master m_axis
);

   localparam int WW = RATIO * DATA_WIDTH;

   if (RATIO < 2) begin : g_bad_ratio
      $error("axis_unpack: RATIO must be >= 2");
   end

   logic [WW-1:0]         buf_data;
   logic                  buf_valid;
   logic                  buf_valid_n;
   logic                  s_ready_q;
   logic                  m_valid_q;
   logic                  advance;
   logic                  drain;
   logic                  accept;
   logic                  last;
   logic                  load;
   logic [WW-1:0]         load_data;
   logic [DATA_WIDTH-1:0] beat;
   logic                  unused_s_tlast;
   load_src_e             src;

   assign unused_s_tlast = s_axis.tlast;

   // handshake decode and choice of the next shift-register word
   always_comb begin
      advance = m_valid_q && m_axis.tready;
      drain   = !m_valid_q || (advance && last);
      accept  = s_axis.tvalid && s_ready_q;
      src     = LD_NONE;
      if (drain) begin
         if (buf_valid)
            src = LD_BUF;
         else if (accept)
            src = LD_BYPASS;
      end
      buf_valid_n = buf_valid;
      if (src == LD_BUF)
         buf_valid_n = 1'b0;
      if (accept && src != LD_BYPASS)
         buf_valid_n = 1'b1;
      load      = src != LD_NONE;
      load_data = (src == LD_BUF) ? buf_data : s_axis.tdata;
   end

   // skid buffer, input ready and output valid registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         buf_data  <= '0;
         buf_valid <= 1'b0;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
      end else begin
         buf_valid <= buf_valid_n;
         s_ready_q <= !buf_valid_n;
         if (accept && src != LD_BYPASS)
            buf_data <= s_axis.tdata;
         if (load)
            m_valid_q <= 1'b1;
         else if (drain)
            m_valid_q <= 1'b0;
      end
   end

   axis_unpack_shift #(
      .DATA_WIDTH (DATA_WIDTH),
      .RATIO      (RATIO),
      .LSB_FIRST  (LSB_FIRST)
   ) u_shift (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (load),
      .advance   (advance && !drain),
      .load_data (load_data),
      .beat      (beat),
      .last      (last)
   );

   assign s_axis.tready = s_ready_q;
   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = beat;
   assign m_axis.tlast  = last;

`ifdef FORMAL
   logic [1:0] pending;
   assign pending = {1'b0, m_valid_q} + {1'b0, buf_valid};

   // a stalled beat must stay put until it is taken
   always @(posedge clock) begin
      if (reset_n && $past(reset_n) && $past(m_axis.tvalid && !m_axis.tready))
         assert (m_axis.tvalid && $stable(m_axis.tdata) && $stable(m_axis.tlast));
      assert (pending <= 2'd2);
   end
`endif

endmodule

// File: tb/tb_axis_unpack.sv
// tb_axis_unpack: directed checks of the wide-to-narrow unpacker,
// LSB-first and MSB-first instances, stalls, random traffic, reset.
module tb_axis_unpack;

   localparam int DW = 8;
   localparam int R  = 4;
   localparam int WW = DW * R;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   axis_unpack_if #(.W(WW)) s_if ();
   axis_unpack_if #(.W(DW)) m_if ();
   axis_unpack_if #(.W(WW)) sm_if ();
   axis_unpack_if #(.W(DW)) mm_if ();

   axis_unpack #(
      .DATA_WIDTH (DW),
      .RATIO      (R),
      .LSB_FIRST  (1)
   ) u_lsb (
      .clock   (clock),
      .reset_n (reset_n),
      .s_axis  (s_if),
      .m_axis  (m_if)
   );

   axis_unpack #(
      .DATA_WIDTH (DW),
      .RATIO      (R),
      .LSB_FIRST  (0)
   ) u_msb (
      .clock   (clock),
      .reset_n (reset_n),
      .s_axis  (sm_if),
      .m_axis  (mm_if)
   );

   int total = 0;
   int bad = 0;
   int nbeat = 0;
   int nlast = 0;
   bit s_en = 1'b0;
   logic [WW-1:0] wq [$];
   logic [DW-1:0] bq [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [WW-1:0] w);
      wq.push_back(w);
      for (int i = 0; i < R; i++)
         bq.push_back(w[DW*i +: DW]);
   endtask

   task automatic feed(input bit hold);
      if (!hold) begin
         s_if.tvalid = (wq.size() > 0) && s_en;
         s_if.tdata  = (wq.size() > 0) ? wq[0] : '0;
      end
   endtask

   // one clock: score the beat taken at the coming edge, then
   // check stall stability and refresh the input side
   task automatic step();
      logic          s_acc;
      logic          m_acc;
      logic          stall;
      logic [DW-1:0] pd;
      logic          pl;
      s_acc = s_if.tvalid && s_if.tready;
      m_acc = m_if.tvalid && m_if.tready;
      stall = m_if.tvalid && !m_if.tready;
      pd = m_if.tdata;
      pl = m_if.tlast;
      if (m_acc) begin
         chk("beat_expected", 32'(bq.size() > 0), 1);
         if (bq.size() > 0)
            chk("beat_data", m_if.tdata, bq.pop_front());
         chk("beat_last", m_if.tlast, (nbeat % R) == R - 1);
         nbeat++;
         if (m_if.tlast)
            nlast++;
      end
      @(negedge clock);
      if (stall)
         chk("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata},
             {1'b1, pl, pd});
      if (s_acc)
         void'(wq.pop_front());
      feed(s_if.tvalid && !s_acc);
   endtask

   initial begin
      logic [DW-1:0] t1 [4];
      logic [DW-1:0] t2 [4];
      logic [13:0]   rdy_pat;
      int            n0;

      t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
      t2 = '{8'h44, 8'h33, 8'h22, 8'h11};
      rdy_pat = 14'b11111000100011;

      s_if.tdata = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      m_if.tready = 1'b0;
      sm_if.tdata = '0;
      sm_if.tvalid = 1'b0;
      sm_if.tlast = 1'b0;
      mm_if.tready = 1'b0;

      // reset state
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_tvalid", m_if.tvalid, 0);
      chk("rst_tlast", m_if.tlast, 0);
      chk("rst_tdata", m_if.tdata, 0);
      chk("rst_sready", s_if.tready, 1);
      reset_n = 1'b1;
      @(negedge clock);

      // single word, LSB first
      s_if.tdata = 32'h44332211;
      s_if.tvalid = 1'b1;
      m_if.tready = 1'b1;
      @(negedge clock);
      s_if.tvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t1_tvalid", m_if.tvalid, 1);
         chk("t1_data", m_if.tdata, t1[i]);
         chk("t1_last", m_if.tlast, i == 3);
         @(negedge clock);
      end
      chk("t1_idle", m_if.tvalid, 0);

      // single word, MSB first
      sm_if.tdata = 32'h44332211;
      sm_if.tvalid = 1'b1;
      mm_if.tready = 1'b1;
      @(negedge clock);
      sm_if.tvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_tvalid", mm_if.tvalid, 1);
         chk("t2_data", mm_if.tdata, t2[i]);
         chk("t2_last", mm_if.tlast, i == 3);
         @(negedge clock);
      end
      chk("t2_idle", mm_if.tvalid, 0);

      // back-to-back words at full rate
      nbeat = 0;
      nlast = 0;
      s_en = 1'b1;
      push_word(32'h04030201);
      push_word(32'h08070605);
      push_word(32'h0c0b0a09);
      feed(1'b0);
      for (int cyc = 0; cyc < 14; cyc++) begin
         chk("t3_sready", s_if.tready, rdy_pat[cyc]);
         chk("t3_tvalid", m_if.tvalid, (cyc >= 1) && (cyc <= 12));
         step();
      end
      chk("t3_left", bq.size(), 0);
      chk("t3_lasts", nlast, 3);

      // output stall after beat 2 with two more words offered
      n0 = nlast;
      push_word(32'h13121110);
      push_word(32'h17161514);
      push_word(32'h1b1a1918);
      feed(1'b0);
      step();
      step();
      m_if.tready = 1'b0;
      chk("t4_full", s_if.tready, 0);
      chk("t4_data", m_if.tdata, 8'h11);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_hold_data", m_if.tdata, 8'h11);
         chk("t4_hold_sready", s_if.tready, 0);
      end
      m_if.tready = 1'b1;
      for (int i = 0; i < 30 && bq.size() > 0; i++)
         step();
      chk("t4_left", bq.size(), 0);
      chk("t4_lasts", nlast - n0, 3);
      chk("t4_idle", m_if.tvalid, 0);

      // random input and output pacing
      for (int c = 0; c < 10000; c++) begin
         if (wq.size() < 2)
            push_word($urandom);
         s_en = $urandom_range(0, 3) != 0;
         m_if.tready = $urandom_range(0, 3) != 0;
         step();
      end
      s_en = 1'b1;
      m_if.tready = 1'b1;
      for (int i = 0; i < 100 && (bq.size() > 0 || wq.size() > 0); i++)
         step();
      chk("t5_left", bq.size(), 0);
      chk("t5_beats", nbeat % R, 0);

      // reset mid-word with the buffer full
      push_word(32'h23222120);
      push_word(32'h27262524);
      push_word(32'h2b2a2928);
      feed(1'b0);
      step();
      step();
      m_if.tready = 1'b0;
      chk("t6_full", s_if.tready, 0);
      #2;
      reset_n = 1'b0;
      s_if.tvalid = 1'b0;
      #1;
      chk("t6_rst_tvalid", m_if.tvalid, 0);
      chk("t6_rst_tlast", m_if.tlast, 0);
      chk("t6_rst_tdata", m_if.tdata, 0);
      chk("t6_rst_sready", s_if.tready, 1);
      wq.delete();
      bq.delete();
      nbeat = 0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("t6_post_idle", m_if.tvalid, 0);
      m_if.tready = 1'b1;
      push_word(32'h3b3a3938);
      feed(1'b0);
      step();
      chk("t6_beat0", m_if.tdata, 8'h38);
      chk("t6_beat0_valid", m_if.tvalid, 1);
      for (int i = 0; i < 10 && bq.size() > 0; i++)
         step();
      chk("t6_left", bq.size(), 0);
      chk("t6_idle", m_if.tvalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
